// File: rtl/i2s_adc_rx.sv
// i2s_adc_rx - WM8731 ADC stream receiver (I2S, codec is clock master).
//
// Re-times AUD_BCLK / AUD_ADCLRCK / AUD_ADCDAT into the system clock,
// deserializes MSB-first left/right words and presents each stereo pair
// over a valid/ready handshake. Framing errors and overruns are sticky.
//
// Ports:
//   clk         system clock, rising edge
//   reset       synchronous, active-high
//   i_bclk      codec bit clock (async)
//   i_lrck      codec word select (async), 0 = left, 1 = right
//   i_adcdat    codec serial data (async)
//   o_left      left sample of presented pair
//   o_right     right sample of presented pair
//   o_valid     pair available, held until accepted
//   i_ready     consumer accepts pair when o_valid && i_ready
//   o_overrun   sticky: completed pair dropped while previous pending
//   o_frame_err sticky: LRCK toggled before a full word was captured
//   i_clear     clears both sticky flags (a same-cycle set wins)
module i2s_adc_rx #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_bclk,
  input  logic                  i_lrck,
  input  logic                  i_adcdat,
  output logic [DATA_WIDTH-1:0] o_left,
  output logic [DATA_WIDTH-1:0] o_right,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic                  o_overrun,
  output logic                  o_frame_err,
  input  logic                  i_clear
);
  localparam int CW = $clog2(DATA_WIDTH + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, WAIT} state_t;

  state_t                state, state_nx;
  logic                  bclk_s1, bclk_s2, bclk_s3;
  logic                  lrck_s1, lrck_s2;
  logic                  dat_s1, dat_s2;
  logic                  lrck_last;
  logic                  chan, chan_nx;
  logic                  left_ok, left_ok_nx;
  logic [CW-1:0]         count, count_nx;
  logic [DATA_WIDTH-1:0] shreg, shreg_nx;
  logic [DATA_WIDTH-1:0] left_hold, left_hold_nx;
  logic [DATA_WIDTH-1:0] word;
  logic                  bclk_rise, lrck_edge;
  logic                  frame_err_set, pair_done, overrun_set;

  assign bclk_rise   = bclk_s2 & ~bclk_s3;
  assign lrck_edge   = bclk_rise & (lrck_s2 != lrck_last);
  // Word as it will look once the current bit is shifted in.
  assign word        = {shreg[DATA_WIDTH-2:0], dat_s2};
  assign overrun_set = pair_done & o_valid & ~i_ready;

  always_comb begin
    state_nx      = state;
    chan_nx       = chan;
    count_nx      = count;
    shreg_nx      = shreg;
    left_hold_nx  = left_hold;
    left_ok_nx    = left_ok;
    frame_err_set = 1'b0;
    pair_done     = 1'b0;
    if (bclk_rise) begin
      case (state)
        IDLE: begin
          // Only a 1->0 LRCK edge (start of a left word) syncs us up.
          // The edge bit is the I2S delay slot, so nothing is shifted.
          if (lrck_edge && !lrck_s2) begin
            chan_nx  = 1'b0;
            count_nx = '0;
            state_nx = SHIFT;
          end
        end
        SHIFT: begin
          if (lrck_edge) begin
            // Short word: drop it and restart on the new channel. Clearing
            // left_ok keeps a stale left from pairing with the next right.
            frame_err_set = 1'b1;
            left_ok_nx    = 1'b0;
            chan_nx       = lrck_s2;
            count_nx      = '0;
          end else begin
            shreg_nx = word;
            count_nx = count + CW'(1);
            if (count == CW'(DATA_WIDTH - 1)) begin
              state_nx = WAIT;
              if (!chan) begin
                left_hold_nx = word;
                left_ok_nx   = 1'b1;
              end else begin
                // Right without a matching left (startup/resync) is dropped.
                pair_done  = left_ok;
                left_ok_nx = 1'b0;
              end
            end
          end
        end
        WAIT: begin
          if (lrck_edge) begin
            chan_nx  = lrck_s2;
            count_nx = '0;
            state_nx = SHIFT;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bclk_s1     <= 1'b0;
      bclk_s2     <= 1'b0;
      bclk_s3     <= 1'b0;
      lrck_s1     <= 1'b0;
      lrck_s2     <= 1'b0;
      dat_s1      <= 1'b0;
      dat_s2      <= 1'b0;
      lrck_last   <= 1'b0;
      state       <= IDLE;
      chan        <= 1'b0;
      count       <= '0;
      shreg       <= '0;
      left_hold   <= '0;
      left_ok     <= 1'b0;
      o_left      <= '0;
      o_right     <= '0;
      o_valid     <= 1'b0;
      o_overrun   <= 1'b0;
      o_frame_err <= 1'b0;
    end else begin
      bclk_s1   <= i_bclk;
      bclk_s2   <= bclk_s1;
      bclk_s3   <= bclk_s2;
      lrck_s1   <= i_lrck;
      lrck_s2   <= lrck_s1;
      dat_s1    <= i_adcdat;
      dat_s2    <= dat_s1;
      if (bclk_rise) lrck_last <= lrck_s2;
      state     <= state_nx;
      chan      <= chan_nx;
      count     <= count_nx;
      shreg     <= shreg_nx;
      left_hold <= left_hold_nx;
      left_ok   <= left_ok_nx;

      // A new pair may replace one being accepted this same cycle.
      if (pair_done && (!o_valid || i_ready)) begin
        o_left  <= left_hold;
        o_right <= word;
        o_valid <= 1'b1;
      end else if (o_valid && i_ready) begin
        o_valid <= 1'b0;
      end

      o_overrun   <= overrun_set   | (o_overrun   & ~i_clear);
      o_frame_err <= frame_err_set | (o_frame_err & ~i_clear);
    end
  end
endmodule
